// File: rtl/udp_rx_ram_reader_pkg.sv
// Shared types and constants for the UDP receive payload RAM reader.
package udp_rx_ram_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } rd_state_e;

    localparam int          UDP_HDR_LEN_DEF = 8;
    localparam logic [15:0] DROP_CNT_MAX    = 16'hFFFF;

endpackage

// File: rtl/udp_rx_ram_reader_if.sv
// Payload byte stream with valid/ready/last handshake.
interface udp_rx_ram_reader_if;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/udp_rd_skid.sv
// Two-entry skid buffer holding {last, data}; entry 0 is always the head.
module udp_rd_skid (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [8:0] din,
    output logic [1:0] count,
    output logic [8:0] head,
    output logic       head_valid
);

    logic [8:0] ent0, ent1;
    logic [1:0] cnt;
    logic       push_ok, pop_ok;

    assign pop_ok     = pop && (cnt != 2'd0);
    assign push_ok    = push && ((cnt != 2'd2) || pop_ok);
    assign count      = cnt;
    assign head       = ent0;
    assign head_valid = (cnt != 2'd0);

    // NOTE: the two entries are only flops, so they are reset to give out_data=0
    // out of reset; a real RAM array would be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0 <= '0;
            ent1 <= '0;
            cnt  <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (cnt == 2'd0) ent0 <= din;
                    else             ent1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    // Head leaves and the new byte takes the tail slot.
                    if (cnt == 2'd1) begin
                        ent0 <= din;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/udp_rx_ram_reader.sv
// Reads a completed UDP payload out of the receive RAM and streams it as bytes.
module udp_rx_ram_reader
    import udp_rx_ram_reader_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int UDP_HDR_LEN = UDP_HDR_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                udp_rec_data_valid,
    input  logic [15:0]         udp_rec_data_length,
    output logic [ADDR_W-1:0]   udp_rec_ram_read_addr,
    input  logic [7:0]          udp_rec_ram_rdata,
    udp_rx_ram_reader_if.master stream,
    output logic                busy,
    output logic                truncated,
    output logic                pkt_drop,
    output logic [15:0]         drop_count
);

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;
    localparam logic [15:0] HDR   = 16'(UDP_HDR_LEN);

    rd_state_e         state, state_next;
    logic [ADDR_W-1:0] addr, last_addr, last_addr_new;
    logic [15:0]       len_raw;
    logic              len_ok, len_big, accept, drop, issue, pop;
    logic              rd_pending, rd_pending_last;
    logic [1:0]        skid_count;
    logic [8:0]        skid_head;
    logic              skid_valid;
    logic [2:0]        occupancy;

    assign len_raw       = udp_rec_data_length - HDR;
    assign len_ok        = udp_rec_data_length > HDR;
    assign len_big       = {1'b0, len_raw} > DEPTH;
    assign last_addr_new = len_big ? {ADDR_W{1'b1}} : ADDR_W'(len_raw - 16'd1);

    assign accept = udp_rec_data_valid && (state == ST_IDLE) && len_ok;
    assign drop   = udp_rec_data_valid && (state != ST_IDLE);
    assign pop    = skid_valid && stream.out_ready;

    // Bytes that will sit in the buffer after this cycle; the pop term keeps
    // one byte per cycle flowing when the consumer is always ready.
    assign occupancy = {1'b0, skid_count} + {2'b00, rd_pending} - {2'b00, pop};

    assign busy                  = (state != ST_IDLE);
    assign udp_rec_ram_read_addr = addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = ST_READ;
            end
            ST_READ: begin
                if (occupancy < 3'd2) begin
                    issue = 1'b1;
                    if (addr == last_addr) state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && skid_head[8]) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr            <= '0;
            last_addr       <= '0;
            rd_pending      <= 1'b0;
            rd_pending_last <= 1'b0;
            truncated       <= 1'b0;
            pkt_drop        <= 1'b0;
            drop_count      <= '0;
        end else begin
            rd_pending      <= issue;
            rd_pending_last <= issue && (addr == last_addr);
            truncated       <= accept && len_big;
            pkt_drop        <= drop;
            if (accept) begin
                addr      <= '0;
                last_addr <= last_addr_new;
            end else if (issue && (addr != last_addr)) begin
                addr <= addr + 1'b1;
            end
            if (drop && (drop_count != DROP_CNT_MAX)) drop_count <= drop_count + 16'd1;
        end
    end

    udp_rd_skid u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (rd_pending),
        .pop        (pop),
        .din        ({rd_pending_last, udp_rec_ram_rdata}),
        .count      (skid_count),
        .head       (skid_head),
        .head_valid (skid_valid)
    );

    assign stream.out_data  = skid_head[7:0];
    assign stream.out_last  = skid_head[8];
    assign stream.out_valid = skid_valid;

endmodule

// File: tb/tb_udp_rx_ram_reader.sv
// Scoreboard bench for udp_rx_ram_reader with a registered-read RAM model.
module tb_udp_rx_ram_reader;

    localparam int ADDR_W = 11;
    localparam int DEPTH  = 2048;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              udp_valid = 1'b0;
    logic [15:0]       udp_len = '0;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_rdata = '0;
    logic              busy, truncated, pkt_drop;
    logic [15:0]       drop_count;

    udp_rx_ram_reader_if stream_if ();

    always #5 clk = ~clk;

    udp_rx_ram_reader #(.ADDR_W(ADDR_W), .UDP_HDR_LEN(8)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .udp_rec_data_valid    (udp_valid),
        .udp_rec_data_length   (udp_len),
        .udp_rec_ram_read_addr (ram_addr),
        .udp_rec_ram_rdata     (ram_rdata),
        .stream                (stream_if),
        .busy                  (busy),
        .truncated             (truncated),
        .pkt_drop              (pkt_drop),
        .drop_count            (drop_count)
    );

    logic [7:0] ram [0:DEPTH-1];
    always @(posedge clk) ram_rdata <= ram[ram_addr];

    int   checks = 0;
    int   failures = 0;
    int   hs_cnt = 0;
    int   last_cnt = 0;
    exp_t exp_q[$];

    // Scoreboard monitor and stall-stability check, sampled mid-cycle.
    logic       stall_prev = 1'b0;
    logic [7:0] held_data;
    logic       held_last;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (stream_if.out_valid !== 1'b1 || stream_if.out_data !== held_data || stream_if.out_last !== held_last) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             stream_if.out_valid, stream_if.out_data, stream_if.out_last, held_data, held_last);
                end
            end
            if (stream_if.out_valid && stream_if.out_ready) begin
                hs_cnt++;
                if (stream_if.out_last) last_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte: got d=%h l=%b want none", stream_if.out_data, stream_if.out_last);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (stream_if.out_data !== e.data || stream_if.out_last !== e.last) begin
                        failures++;
                        $display("FAIL byte: got d=%h l=%b want d=%h l=%b",
                                 stream_if.out_data, stream_if.out_last, e.data, e.last);
                    end
                end
            end
            stall_prev = stream_if.out_valid && !stream_if.out_ready;
            held_data  = stream_if.out_data;
            held_last  = stream_if.out_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [15:0] len);
        udp_valid = 1'b1;
        udp_len   = len;
        step();
        udp_valid = 1'b0;
        udp_len   = '0;
    endtask

    task automatic load_pkt(input int n, input int seed);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            ram[i] = 8'(seed + i * 37 + (i >> 5));
            e.data = ram[i];
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (ram_addr !== '0 || stream_if.out_data !== 8'h00 || stream_if.out_valid !== 1'b0 || stream_if.out_last !== 1'b0) begin
            failures++;
            $display("FAIL %s_stream: got a=%h d=%h v=%b l=%b want all 0", tag, ram_addr,
                     stream_if.out_data, stream_if.out_valid, stream_if.out_last);
        end
        checks++;
        if (busy !== 1'b0 || truncated !== 1'b0 || pkt_drop !== 1'b0 || drop_count !== 16'd0) begin
            failures++;
            $display("FAIL %s_status: got busy=%b trunc=%b drop=%b cnt=%0d want 0 0 0 0", tag, busy,
                     truncated, pkt_drop, drop_count);
        end
    endtask

    task automatic test_reset();
        stream_if.out_ready = 1'b1;
        step();
        step();
        check_reset_values("reset");
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        exp_t e;
        bit   ok;
        for (int i = 0; i < 4; i++) begin
            ram[i] = 8'hA0 + 8'(i);
            e.data = ram[i];
            e.last = (i == 3);
            exp_q.push_back(e);
        end
        pulse(16'd12);                                                  // now T+1
        checks++;
        if (ram_addr !== '0 || busy !== 1'b1) begin
            failures++; $display("FAIL basic_t1: got a=%h busy=%b want a=0 busy=1", ram_addr, busy);
        end
        step();                                                         // T+2
        checks++;
        if (stream_if.out_valid !== 1'b0) begin
            failures++; $display("FAIL basic_t2_valid: got %b want 0", stream_if.out_valid);
        end
        step();                                                         // T+3
        checks++;
        if (stream_if.out_valid !== 1'b1 || stream_if.out_data !== 8'hA0) begin
            failures++; $display("FAIL basic_t3_first: got v=%b d=%h want v=1 d=a0", stream_if.out_valid, stream_if.out_data);
        end
        step(); step(); step();                                         // T+6
        checks++;
        if (stream_if.out_last !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL basic_t6_last: got l=%b busy=%b want 1 1", stream_if.out_last, busy);
        end
        step();                                                         // T+7
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            failures++; $display("FAIL basic_t7_done: got busy=%b left=%0d want 0 0", busy, exp_q.size());
        end
        wait_idle(20, ok);
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   hs0, last0;
        logic [5:0] pat;
        pat   = 6'b101001;
        hs0   = hs_cnt;
        last0 = last_cnt;
        load_pkt(6, 8'h51);
        pulse(16'd14);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            stream_if.out_ready = pat[i % 6];
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        stream_if.out_ready = 1'b1;
        checks++;
        if (!ok || hs_cnt - hs0 != 6 || last_cnt - last0 != 1) begin
            failures++;
            $display("FAIL backpressure: got done=%b bytes=%0d lasts=%0d want 1 6 1", ok, hs_cnt - hs0, last_cnt - last0);
        end
    endtask

    task automatic test_ignore();
        bit seen_v, seen_b, seen_d;
        seen_v = 1'b0; seen_b = 1'b0; seen_d = 1'b0;
        pulse(16'd8);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                udp_valid = 1'b1; udp_len = 16'd3;
            end else begin
                udp_valid = 1'b0; udp_len = '0;
            end
            seen_v |= stream_if.out_valid;
            seen_b |= busy;
            seen_d |= pkt_drop;
            step();
        end
        checks++;
        if (seen_v !== 1'b0 || seen_b !== 1'b0 || seen_d !== 1'b0) begin
            failures++; $display("FAIL ignore_short: got valid=%b busy=%b drop=%b want 0 0 0", seen_v, seen_b, seen_d);
        end
    endtask

    task automatic test_truncate();
        bit ok;
        int hs0, last0;
        hs0   = hs_cnt;
        last0 = last_cnt;
        load_pkt(DEPTH, 8'h17);
        pulse(16'd3008);                                                // T+1
        checks++;
        if (truncated !== 1'b1) begin
            failures++; $display("FAIL trunc_pulse: got %b want 1", truncated);
        end
        step();
        checks++;
        if (truncated !== 1'b0) begin
            failures++; $display("FAIL trunc_one_cycle: got %b want 0", truncated);
        end
        wait_idle(DEPTH + 50, ok);
        checks++;
        if (!ok || hs_cnt - hs0 != DEPTH || last_cnt - last0 != 1 || ram_addr !== 11'd2047) begin
            failures++;
            $display("FAIL trunc_count: got done=%b bytes=%0d lasts=%0d addr=%0d want 1 2048 1 2047",
                     ok, hs_cnt - hs0, last_cnt - last0, ram_addr);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        load_pkt(10, 8'h6B);
        pulse(16'd18);                                                  // T+1
        step(); step(); step();                                         // T+4
        pulse(16'd13);                                                  // T+5
        checks++;
        if (pkt_drop !== 1'b1 || drop_count !== 16'd1 || busy !== 1'b1) begin
            failures++; $display("FAIL drop_pulse: got drop=%b cnt=%0d busy=%b want 1 1 1", pkt_drop, drop_count, busy);
        end
        step();                                                         // T+6
        checks++;
        if (pkt_drop !== 1'b0) begin
            failures++; $display("FAIL drop_one_cycle: got %b want 0", pkt_drop);
        end
        for (int i = 0; i < 7; i++) step();                             // T+13
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            failures++; $display("FAIL first_done: got busy=%b left=%0d want 0 0", busy, exp_q.size());
        end
        load_pkt(3, 8'hC4);
        pulse(16'd11);                                                  // T+14
        checks++;
        if (busy !== 1'b1 || pkt_drop !== 1'b0 || drop_count !== 16'd1 || ram_addr !== '0) begin
            failures++;
            $display("FAIL accept_after_last: got busy=%b drop=%b cnt=%0d a=%0d want 1 0 1 0", busy, pkt_drop, drop_count, ram_addr);
        end
        wait_idle(30, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL second_pkt_timeout: got left=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_edge_drop();
        bit seen_v;
        load_pkt(2, 8'h92);
        pulse(16'd10);                                                  // T+1
        step(); step(); step();                                         // T+4, last handshake
        pulse(16'd15);                                                  // T+5
        checks++;
        if (pkt_drop !== 1'b1 || drop_count !== 16'd2 || busy !== 1'b0) begin
            failures++; $display("FAIL edge_drop: got drop=%b cnt=%0d busy=%b want 1 2 0", pkt_drop, drop_count, busy);
        end
        seen_v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen_v |= stream_if.out_valid | busy;
            step();
        end
        checks++;
        if (seen_v !== 1'b0) begin
            failures++; $display("FAIL edge_drop_quiet: got activity=%b want 0", seen_v);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int hs0, last0;
        hs0   = hs_cnt;
        last0 = last_cnt;
        load_pkt(20, 8'h2D);
        pulse(16'd28);
        for (int i = 0; i < 6; i++) step();
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        exp_q.delete();
        step(); step();
        rst_n = 1'b1;
        step();
        load_pkt(5, 8'hE8);
        pulse(16'd13);
        checks++;
        if (ram_addr !== '0 || busy !== 1'b1) begin
            failures++; $display("FAIL post_reset_t1: got a=%h busy=%b want 0 1", ram_addr, busy);
        end
        wait_idle(30, ok);
        checks++;
        if (!ok || last_cnt - last0 != 1 || hs_cnt - hs0 < 5) begin
            failures++;
            $display("FAIL post_reset_stream: got done=%b lasts=%0d bytes=%0d want 1 1 >=5", ok, last_cnt - last0, hs_cnt - hs0);
        end
    endtask

    initial begin
        stream_if.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'h00;
        test_reset();
        test_basic();
        test_backpressure();
        test_ignore();
        test_truncate();
        test_back_to_back();
        test_edge_drop();
        test_reset_mid();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
